// File: rtl/reg_file_pkg.sv
// Shared constants and types for the decode-stage register file.
// Optional write-through bypass is selected with REGFILE_WRITE_BYPASS_EN.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] data_word_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
    localparam reg_idx_t REG_RA   = reg_idx_t'(31);

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: zero-index mask plus optional write-through bypass.
// Bypass compiled in only when REGFILE_WRITE_BYPASS_EN is defined.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
)
(
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] stored_word,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_word,
`endif
    output logic [DATA_W-1:0] rd_word
);

    always_comb begin
        rd_word = stored_word;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && (wr_idx != ADDR_W'(REG_ZERO)) && (wr_idx == rd_idx))
            rd_word = wr_word;
`endif
        // r0 wins over everything, including a bypassed write
        if (rd_idx == ADDR_W'(REG_ZERO))
            rd_word = '0;
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file, three combinational read ports and one synchronous write port.
// Define REGFILE_WRITE_BYPASS_EN for same-cycle write-through on the read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = reg_file_pkg::DATA_W,
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_file_pkg::ADDR_W
)
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RegA1,
    input  logic [ADDR_W-1:0] RegB1,
    input  logic [ADDR_W-1:0] RegC1,
    output logic [DATA_W-1:0] DataA1,
    output logic [DATA_W-1:0] DataB1,
    output logic [DATA_W-1:0] DataC1,
    input  logic [ADDR_W-1:0] WriteReg1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              Write1
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_accept;

    assign wr_accept = Write1 && (WriteReg1 != ADDR_W'(REG_ZERO));

    // Reset clears the whole array and takes priority over a concurrent write
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_accept) begin
            regs[WriteReg1] <= WriteData1;
        end
    end

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .rd_idx      (RegA1),
        .stored_word (regs[RegA1]),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wr_en       (Write1),
        .wr_idx      (WriteReg1),
        .wr_word     (WriteData1),
`endif
        .rd_word     (DataA1)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .rd_idx      (RegB1),
        .stored_word (regs[RegB1]),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wr_en       (Write1),
        .wr_idx      (WriteReg1),
        .wr_word     (WriteData1),
`endif
        .rd_word     (DataB1)
    );

    reg_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_c (
        .rd_idx      (RegC1),
        .stored_word (regs[RegC1]),
`ifdef REGFILE_WRITE_BYPASS_EN
        .wr_en       (Write1),
        .wr_idx      (WriteReg1),
        .wr_word     (WriteData1),
`endif
        .rd_word     (DataC1)
    );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed cases plus random traffic against an array model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    reg_idx_t   RegA1, RegB1, RegC1, WriteReg1;
    data_word_t DataA1, DataB1, DataC1, WriteData1;
    logic       Write1;

    reg_file dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RegA1      (RegA1),
        .RegB1      (RegB1),
        .RegC1      (RegC1),
        .DataA1     (DataA1),
        .DataB1     (DataB1),
        .DataC1     (DataC1),
        .WriteReg1  (WriteReg1),
        .WriteData1 (WriteData1),
        .Write1     (Write1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        data_word_t a;
        data_word_t b;
        data_word_t c;
        int         tag;
    } exp_t;

    exp_t       sb_q[$];
    data_word_t model [NUM_REGS];
    bit         model_ok = 0;
    int         checks = 0;
    int         errors = 0;
    int         tag_cnt = 0;

    // Architectural rule: r0 reads 0; optional write-through; otherwise stored value.
    function automatic data_word_t ref_read(reg_idx_t idx, logic we, reg_idx_t widx, data_word_t wd);
        if (idx == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && widx != 0 && widx == idx) return wd;
`endif
        return model[idx];
    endfunction

    task automatic cycle(input logic rst, input logic we, input reg_idx_t widx, input data_word_t wd,
                         input reg_idx_t ra, input reg_idx_t rb, input reg_idx_t rc);
        exp_t e;
        RESET = rst; Write1 = we; WriteReg1 = widx; WriteData1 = wd;
        RegA1 = ra; RegB1 = rb; RegC1 = rc;
        if (model_ok) begin
            e.a = ref_read(ra, we, widx, wd);
            e.b = ref_read(rb, we, widx, wd);
            e.c = ref_read(rc, we, widx, wd);
            e.tag = tag_cnt++;
            sb_q.push_back(e);
        end
        @(posedge CLK);
        if (rst) begin
            foreach (model[i]) model[i] = '0;
            model_ok = 1;
        end else if (we && widx != 0) begin
            model[widx] = wd;
        end
        #1;
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result at mid-cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (DataA1 !== e.a || DataB1 !== e.b || DataC1 !== e.c) begin
                errors++;
                $display("FAIL read#%0d A=%h/%h B=%h/%h C=%h/%h (got/exp) idx=%0d,%0d,%0d",
                         e.tag, DataA1, e.a, DataB1, e.b, DataC1, e.c, RegA1, RegB1, RegC1);
            end
        end
    end

    initial begin
        reg_idx_t   ra, rb, rc, wi;
        data_word_t wd;
        logic       we, rs;

        RESET = 1; Write1 = 0; WriteReg1 = '0; WriteData1 = '0;
        RegA1 = '0; RegB1 = '0; RegC1 = '0;
        @(posedge CLK); #1;

        // reset then read
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 5, 31, 0);
        // write / read back on all ports
        cycle(0, 1, 8, 32'hDEADBEEF, 1, 2, 3);
        cycle(0, 0, 0, 0, 8, 8, 8);
        // r0 immutable
        cycle(0, 1, 0, 32'h12345678, 0, 0, 8);
        cycle(0, 0, 0, 0, 0, 8, 0);
        // same-cycle read/write on reg 9
        cycle(0, 1, 9, 32'h1, 0, 0, 0);
        cycle(0, 1, 9, 32'h2, 9, 9, 8);
        cycle(0, 0, 0, 0, 9, 9, 9);
        // reset priority over write
        cycle(0, 1, 3, 32'hAAAA5555, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 3, 3);
        cycle(1, 1, 3, 32'h0000FFFF, 3, 9, 8);
        cycle(0, 0, 0, 0, 3, 9, 8);
        // write enable low
        repeat (3) cycle(0, 0, 4, 32'h77, 4, 4, 4);
        cycle(0, 0, 0, 0, 4, REG_RA, 0);
        // r31 boundary
        cycle(0, 1, REG_RA, 32'hFFFFFFFF, REG_RA, 30, 0);
        cycle(0, 0, 0, 0, REG_RA, REG_RA, 30);

        // random traffic, reads biased toward a small index pool to hit written regs
        for (int n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 59) == 0);
            we = ($urandom_range(0, 3) != 0);
            wi = reg_idx_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wd = $urandom;
            ra = reg_idx_t'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            rb = reg_idx_t'(($urandom_range(0, 3) == 0) ? wi : $urandom_range(0, 7));
            rc = reg_idx_t'($urandom_range(0, 31));
            cycle(rs, we, wi, wd, ra, rb, rc);
        end

        Write1 = 0; RESET = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

endmodule
